// File: rtl/multdiv_ctrl_if.sv
// Issue, multdiv-control and writeback signals of the multdiv issue controller.
// master = controller side, slave = environment (X stage, multdiv, regfile).
interface multdiv_ctrl_if;
  logic        issue_valid;
  logic        issue_div;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [4:0]  issue_rd;
  logic [31:0] md_operandA;
  logic [31:0] md_operandB;
  logic        md_ctrl_MULT;
  logic        md_ctrl_DIV;
  logic [31:0] md_result;
  logic        md_exception;
  logic        md_resultRDY;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        timeout;

  modport master (
    input  issue_valid, issue_div, issue_a, issue_b, issue_rd,
    input  md_result, md_exception, md_resultRDY,
    output md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    output stall, busy, wb_valid, wb_rd, wb_data, timeout
  );

  modport slave (
    output issue_valid, issue_div, issue_a, issue_b, issue_rd,
    output md_result, md_exception, md_resultRDY,
    input  md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV,
    input  stall, busy, wb_valid, wb_rd, wb_data, timeout
  );
endinterface

// File: rtl/multdiv_ctrl.sv
// Issue/writeback controller for the multi-cycle multdiv unit (IDLE -> BUSY -> DONE).
// Define MULTDIV_TIMEOUT_EN to enable the BUSY-cycle watchdog and sticky timeout flag.
module multdiv_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int RSTATUS_REG    = 30,
  parameter int MULT_EXC_CODE  = 4,
  parameter int DIV_EXC_CODE   = 5
) (
  input logic           clock,
  input logic           reset,
  multdiv_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_next;
  logic        op_div;
  logic [4:0]  rd_saved;
  logic        accept;
  logic        launch;
  logic        rdy_ok;
  logic        expire;
  logic        finish;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  function automatic logic [31:0] exc_code(input logic div);
    return div ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
  endfunction

  assign accept = (state == IDLE) && bus.issue_valid;
  // The start pulse marks the launch cycle, where RDY may still be left over from the last op.
  assign launch = bus.md_ctrl_MULT | bus.md_ctrl_DIV;
  assign rdy_ok = (state == BUSY) && !launch && bus.md_resultRDY;
  assign finish = rdy_ok | expire;
  assign bus.stall = accept || (state == BUSY);

`ifdef MULTDIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             timeout_q;

  // cnt holds the index of the current BUSY cycle, so the limit trips in BUSY cycle TIMEOUT_CYCLES.
  assign expire      = (state == BUSY) && !rdy_ok && (cnt == CNT_W'(TIMEOUT_CYCLES));
  assign bus.timeout = timeout_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept)
        cnt <= CNT_W'(1);
      else if ((state == BUSY) && (cnt != CNT_W'(TIMEOUT_CYCLES)))
        cnt <= cnt + 1'b1;
      if (expire)
        timeout_q <= 1'b1;
    end
  end
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.issue_valid) state_next = BUSY;
      BUSY:    if (finish) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      op_div           <= 1'b0;
      rd_saved         <= '0;
      bus.md_operandA  <= '0;
      bus.md_operandB  <= '0;
      bus.md_ctrl_MULT <= 1'b0;
      bus.md_ctrl_DIV  <= 1'b0;
      bus.busy         <= 1'b0;
      bus.wb_valid     <= 1'b0;
      bus.wb_rd        <= '0;
      bus.wb_data      <= '0;
    end else begin
      state            <= state_next;
      bus.busy         <= (state_next != IDLE);
      bus.md_ctrl_MULT <= accept && !bus.issue_div;
      bus.md_ctrl_DIV  <= accept && bus.issue_div;
      bus.wb_valid     <= finish;
      if (accept) begin
        bus.md_operandA <= bus.issue_a;
        bus.md_operandB <= bus.issue_b;
        rd_saved        <= bus.issue_rd;
        op_div          <= bus.issue_div;
      end
      // A watchdog expiry reports like a multdiv exception.
      if (finish) begin
        if (rdy_ok && !bus.md_exception) begin
          bus.wb_rd   <= rd_saved;
          bus.wb_data <= bus.md_result;
        end else begin
          bus.wb_rd   <= 5'(RSTATUS_REG);
          bus.wb_data <= exc_code(op_div);
        end
      end
    end
  end

endmodule
